// File: rtl/spi_sd_pkg.sv
// Shared types and defaults for the SPI SD-card router.
// Holds the router FSM state enum and the default activity timeout.
package spi_sd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        SWITCH = 2'd2
    } spi_state_e;

    localparam int SPI_TIMEOUT_DFLT = 1000000;
    localparam int SPI_MAX_TGT      = 8;

endpackage

// File: rtl/spi_act_timer.sv
// SPI activity timer: counts clk cycles since the last change on MOSI/MISO.
// Ports: clk_sys, rst_n, mosi_i, miso_i (lines watched), act_o (activity).
module spi_act_timer
    import spi_sd_pkg::*;
#(
    parameter int TIMEOUT = SPI_TIMEOUT_DFLT
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic mosi_i,
    input  logic miso_i,
    output logic act_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mosi_q, miso_q;

    // Any edge on either data line restarts the quiet-time count;
    // otherwise count up and park at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if ((mosi_i != mosi_q) || (miso_i != miso_q)) begin
            cnt_d = '0;
        end else if (cnt_q < CMAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CMAX;
            mosi_q <= 1'b0;
            miso_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mosi_q <= mosi_i;
            miso_q <= miso_i;
        end
    end

    assign act_o = (cnt_q < CMAX);

endmodule

// File: rtl/spi_sd_router.sv
// Routes one SPI master to the physical SD card (target 0) or to the lowest
// mounted virtual image card; retargets only between transactions.
// Ports: clk_sys, rst_n; master m_sck/m_mosi/m_ss in, m_miso out;
// per-target t_sck/t_mosi/t_ss out, t_miso in; img_mounted/img_nz mount
// strobes; sel (routed target), act (activity).
// Optional macro SPI_SD_ROUTER_ACT_EN enables the activity timer; without
// it act is tied low.
module spi_sd_router
    import spi_sd_pkg::*;
#(
    parameter int NUM_TGT = 2,
    parameter int TIMEOUT = SPI_TIMEOUT_DFLT
) (
    input  logic                       clk_sys,
    input  logic                       rst_n,
    input  logic                       m_sck,
    input  logic                       m_mosi,
    input  logic                       m_ss,
    output logic                       m_miso,
    output logic [NUM_TGT-1:0]         t_sck,
    output logic [NUM_TGT-1:0]         t_mosi,
    output logic [NUM_TGT-1:0]         t_ss,
    input  logic [NUM_TGT-1:0]         t_miso,
    input  logic [NUM_TGT-1:0]         img_mounted,
    input  logic [NUM_TGT-1:0]         img_nz,
    output logic [$clog2(NUM_TGT)-1:0] sel,
    output logic                       act
);

    localparam int SW = $clog2(NUM_TGT);

    spi_state_e           state_q;
    logic [SW-1:0]        sel_q;
    logic [NUM_TGT-1:1]   mounted_q;
    logic [SW-1:0]        pend;

    // Target 0 is the physical card and cannot be (un)mounted.
    logic unused_tgt0;
    assign unused_tgt0 = ^{img_mounted[0], img_nz[0]};

    // Lowest mounted image wins; fall back to the physical card.
    always_comb begin
        pend = '0;
        for (int i = NUM_TGT - 1; i >= 1; i--) begin
            if (mounted_q[i]) begin
                pend = SW'(i);
            end
        end
    end

    // A falling m_ss in IDLE always wins over a pending retarget, so a
    // transaction never sees its target change underneath it.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            mounted_q <= '0;
        end else begin
            for (int i = 1; i < NUM_TGT; i++) begin
                if (img_mounted[i]) begin
                    mounted_q[i] <= img_nz[i];
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (!m_ss) begin
                        state_q <= BUSY;
                    end else if (pend != sel_q) begin
                        state_q <= SWITCH;
                        sel_q   <= pend;
                    end
                end
                BUSY: begin
                    if (m_ss) begin
                        state_q <= IDLE;
                    end
                end
                SWITCH: begin
                    state_q <= m_ss ? IDLE : BUSY;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Zero-latency pass-through; everything is parked during SWITCH.
    always_comb begin
        t_ss   = '1;
        t_sck  = '0;
        t_mosi = '0;
        m_miso = 1'b1;
        if (state_q != SWITCH) begin
            t_ss[sel_q]   = m_ss;
            t_sck[sel_q]  = m_sck;
            t_mosi[sel_q] = m_mosi;
            m_miso        = t_miso[sel_q];
        end
    end

    assign sel = sel_q;

`ifdef SPI_SD_ROUTER_ACT_EN
    spi_act_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_act (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .mosi_i  (m_mosi),
        .miso_i  (m_miso),
        .act_o   (act)
    );
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
    assign act = 1'b0;
`endif

endmodule
